// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch slice.
// FETCH_TIMEOUT_EN adds the default ack-watchdog limit.
package fetch_pkg;

    localparam int unsigned FETCH_PC_BITS    = 6;
    localparam int unsigned FETCH_BYTE_BITS  = 8;
    localparam int unsigned FETCH_INSTR_BITS = 2 * FETCH_BYTE_BITS;
`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned FETCH_TIMEOUT_CYCLES = 15;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        HOLD   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Byte-memory req/ack bus plus decoder valid/ready handshake for instr_fetch.
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_BITS   = FETCH_PC_BITS,
    parameter int unsigned BYTE_BITS = FETCH_BYTE_BITS
) ();

    localparam int unsigned INSTR_BITS = 2 * BYTE_BITS;

    logic                  mem_req;
    logic [PC_BITS-1:0]    mem_addr;
    logic [BYTE_BITS-1:0]  mem_rdata;
    logic                  mem_ack;
    logic [INSTR_BITS-1:0] instr_out;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        output mem_req, mem_addr, instr_out, instr_valid,
        input  mem_rdata, mem_ack, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_out, instr_valid,
        output mem_rdata, mem_ack, instr_ready
    );

endinterface

// File: rtl/fetch_watchdog.sv
// Ack watchdog: counts stalled request cycles, flags expiry on the limit-th one.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clka,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] count_q;

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + CNT_BITS'(1);
        end
    end

    // Combinational so the FSM leaves on the same edge that ends the last stalled cycle.
    assign expired = count_en && (count_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch.sv
// Fetches a little-endian 16-bit instruction as two byte reads at an even PC.
// Optional FETCH_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES without ack.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned PC_BITS   = FETCH_PC_BITS,
    parameter int unsigned BYTE_BITS = FETCH_BYTE_BITS
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
`endif
) (
    input  logic               clka,
    input  logic               reset,
    input  logic [PC_BITS-1:0] pc_in,
    input  logic               fetch_start,
    instr_fetch_if.master      bus,
    output logic               busy,
    output logic               fetch_err
);

    localparam int unsigned INSTR_BITS = 2 * BYTE_BITS;

    fetch_state_t          state_q, state_d;
    logic [PC_BITS-1:0]    pc_cap_q;
    logic [PC_BITS-1:0]    mem_addr_q;
    logic                  mem_req_q;
    logic [INSTR_BITS-1:0] instr_q;
    logic                  err_q, err_d;
    logic                  ack;
    logic                  timeout;

    assign ack = mem_req_q && bus.mem_ack;

`ifdef FETCH_TIMEOUT_EN
    logic wd_clear;
    logic wd_en;

    assign wd_clear = (state_d != state_q) && ((state_d == REQ_LO) || (state_d == REQ_HI));
    assign wd_en    = mem_req_q && !bus.mem_ack;

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clka     (clka),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_en),
        .expired  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    if (pc_in[0]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ_LO;
                    end
                end
            end
            REQ_LO: begin
                if (ack) begin
                    state_d = REQ_HI;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            REQ_HI: begin
                if (ack) begin
                    state_d = HOLD;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_cap_q   <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            // Request line tracks the next state so it is registered yet aligned with REQ_*.
            mem_req_q <= (state_d == REQ_LO) || (state_d == REQ_HI);
            if ((state_q == IDLE) && (state_d == REQ_LO)) begin
                pc_cap_q   <= pc_in;
                mem_addr_q <= pc_in;
            end
            if ((state_q == REQ_LO) && ack) begin
                instr_q[BYTE_BITS-1:0] <= bus.mem_rdata;
                mem_addr_q             <= pc_cap_q | PC_BITS'(1);
            end
            if ((state_q == REQ_HI) && ack) begin
                instr_q[INSTR_BITS-1:BYTE_BITS] <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign busy            = (state_q != IDLE);
    assign fetch_err       = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (timeout steps only with FETCH_TIMEOUT_EN).
module tb_instr_fetch;

    logic       clka = 1'b0;
    logic       reset;
    logic [5:0] pc_in;
    logic       fetch_start;
    logic       busy;
    logic       fetch_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clka        (clka),
        .reset       (reset),
        .pc_in       (pc_in),
        .fetch_start (fetch_start),
        .bus         (bus),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clka = ~clka;

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        pc_in           = '0;
        fetch_start     = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.instr_ready = 1'b0;
        step();
        step();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_instr_out", bus.instr_out, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", fetch_err, 0);
        reset = 1'b1;
        step();

        // Basic fetch, zero wait states
        pc_in = 6'h04; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_req_lo", bus.mem_req, 1);
        chk("t1_addr_lo", bus.mem_addr, 6'h04);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h34;
        step();
        chk("t1_req_hi", bus.mem_req, 1);
        chk("t1_addr_hi", bus.mem_addr, 6'h05);
        chk("t1_valid_early", bus.instr_valid, 0);
        bus.mem_rdata = 8'h12;
        step();
        bus.mem_ack = 1'b0;
        chk("t1_valid", bus.instr_valid, 1);
        chk("t1_word", bus.instr_out, 16'h1234);
        chk("t1_req_off", bus.mem_req, 0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t1_valid_clr", bus.instr_valid, 0);
        chk("t1_idle", busy, 0);

        // Three wait states per byte; stray ready during REQ has no effect
        pc_in = 6'h10; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_lo_req", bus.mem_req, 1);
            chk("t2_lo_addr", bus.mem_addr, 6'h10);
            chk("t2_lo_busy", busy, 1);
        end
        bus.instr_ready = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAB;
        step();
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hi_addr", bus.mem_addr, 6'h11);
            chk("t2_hi_valid", bus.instr_valid, 0);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hCD;
        step();
        bus.mem_ack = 1'b0;
        chk("t2_valid", bus.instr_valid, 1);
        chk("t2_word", bus.instr_out, 16'hCDAB);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t2_idle", busy, 0);

        // Misaligned PC, then ack while idle is ignored
        pc_in = 6'h05; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("t3_err", fetch_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_req", bus.mem_req, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
        step();
        bus.mem_ack = 1'b0;
        chk("t3_err_pulse", fetch_err, 0);
        chk("t3_req2", bus.mem_req, 0);
        chk("t3_busy2", busy, 0);

        // Backpressure with fetch_start pulsing meanwhile
        pc_in = 6'h20; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h78;
        step();
        bus.mem_rdata = 8'h56;
        step();
        bus.mem_ack = 1'b0;
        pc_in = 6'h30;
        for (int i = 0; i < 5; i++) begin
            fetch_start = (i % 2 == 0);
            step();
            chk("t4_word", bus.instr_out, 16'h5678);
            chk("t4_valid", bus.instr_valid, 1);
            chk("t4_no_req", bus.mem_req, 0);
        end
        bus.instr_ready = 1'b1; fetch_start = 1'b1;
        step();
        bus.instr_ready = 1'b0; fetch_start = 1'b0;
        chk("t4_start_ignored", busy, 0);
        chk("t4_req_ignored", bus.mem_req, 0);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("t4_new_addr", bus.mem_addr, 6'h30);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hBC;
        step();
        bus.mem_rdata = 8'h9A;
        step();
        bus.mem_ack = 1'b0;
        chk("t4_new_word", bus.instr_out, 16'h9ABC);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Asynchronous reset while in REQ_HI
        pc_in = 6'h3C; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEF;
        step();
        bus.mem_ack = 1'b0;
        chk("t5_addr_hi", bus.mem_addr, 6'h3D);
        #2 reset = 1'b0;
        #1;
        chk("t5_req", bus.mem_req, 0);
        chk("t5_addr", bus.mem_addr, 0);
        chk("t5_instr", bus.instr_out, 0);
        chk("t5_busy", busy, 0);
        step();
        reset = 1'b1;
        step();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("t5_refetch_addr", bus.mem_addr, 6'h3C);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
        step();
        bus.mem_rdata = 8'h22;
        step();
        bus.mem_ack = 1'b0;
        chk("t5_word", bus.instr_out, 16'h2211);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Never acked: abort after 15 stalled cycles
        pc_in = 6'h08; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t6_req_held", bus.mem_req, 1);
        end
        step();
        chk("t6_req_drop", bus.mem_req, 0);
        chk("t6_err", fetch_err, 1);
        chk("t6_idle", busy, 0);
        step();
        chk("t6_err_pulse", fetch_err, 0);
        chk("t6_no_valid", bus.instr_valid, 0);

        // Ack on the 15th stalled cycle wins
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h55;
        step();
        chk("t7_req", bus.mem_req, 1);
        chk("t7_addr", bus.mem_addr, 6'h09);
        chk("t7_no_err", fetch_err, 0);
        bus.mem_rdata = 8'hAA;
        step();
        bus.mem_ack = 1'b0;
        chk("t7_word", bus.instr_out, 16'hAA55);
        chk("t7_valid", bus.instr_valid, 1);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer side of the program-counter interface.
- Takes the current PC value and, on a start strobe from the control FSM, reads two consecutive bytes from byte-wide instruction memory over a req/ack handshake.
- Assembles the two bytes into one 16-bit instruction word and presents it to the decoder with a valid/ready handshake.
- Flags misaligned PCs to the FSM.

Parameters:
- PC_BITS, 6, width of the PC and memory byte address (64-byte space).
- INSTR_BITS, 16, instruction word width; fixed at 2 × BYTE_BITS.
- BYTE_BITS, 8, memory data width.
- TIMEOUT_CYCLES, 15, ack watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clka  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_in  in  PC_BITS  current PC value, sampled on an accepted fetch_start.
- fetch_start  in  1  FSM request to fetch at pc_in.
- mem_req  out  1  memory read request.
- mem_addr  out  PC_BITS  memory byte address.
- mem_rdata  in  BYTE_BITS  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completes the current request this cycle.
- instr_out  out  INSTR_BITS  assembled instruction.
- instr_valid  out  1  instr_out holds a complete instruction.
- instr_ready  in  1  decoder accepts instr_out.
- busy  out  1  high in every state except IDLE.
- fetch_err  out  1  one-cycle error pulse.

Behaviour:
- Reset, asynchronous on reset=0:
  - state=IDLE.
  - mem_req=0, mem_addr=0.
  - instr_out=0, instr_valid=0.
  - busy=0, fetch_err=0.
  - Internal PC capture and byte registers = 0.
- States: IDLE, REQ_LO, REQ_HI, HOLD.
- IDLE:
  - fetch_start=1 and pc_in[0]=0: capture pc_in into pc_cap, go to REQ_LO.
  - fetch_start=1 and pc_in[0]=1: fetch_err=1 next cycle, remain in IDLE, no memory access.
- REQ_LO:
  - mem_req=1, mem_addr=pc_cap.
  - On mem_ack: instr_out[7:0]←mem_rdata, go to REQ_HI.
- REQ_HI:
  - mem_req=1, mem_addr=pc_cap|1. No carry into upper bits, because pc_cap is even, so no wrap occurs.
  - On mem_ack: instr_out[15:8]←mem_rdata, instr_valid=1, go to HOLD.
- Handshake outputs:
  - mem_req and mem_addr are registered.
  - Each cycle with mem_ack=1 consumes exactly one request.
  - mem_ack while mem_req=0 is ignored.
- HOLD:
  - instr_valid=1; instr_out stable until accepted.
  - On instr_ready: instr_valid=0, go to IDLE.
- fetch_start outside IDLE is ignored, including in the same cycle as the accepting instr_ready. The FSM must re-assert it.
- Minimum latency, with ack on the first cycle of each request:
  - fetch_start sampled at edge N.
  - mem_req high from N+1.
  - instr_valid high from N+3.
  - Back-to-back fetches: next fetch_start accepted at the edge after the ready handshake completes.
- Byte order is little-endian: even address → instr_out[7:0].
- instr_ready while not in HOLD has no effect.
- Reset asserted mid-fetch aborts immediately to the reset values; any partial word is discarded.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ_LO or REQ_HI and counts each cycle mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: deassert mem_req, pulse fetch_err for 1 cycle, return to IDLE, instr_valid stays 0.
  - mem_ack in the same cycle the limit is reached takes priority (no timeout).
- Undefined: no counter; REQ states wait indefinitely for mem_ack.

Decomposition:
- Shared package fetch_pkg holds:
  - State encoding: IDLE=2'd0, REQ_LO=2'd1, REQ_HI=2'd2, HOLD=2'd3.
  - Default PC_BITS, BYTE_BITS and INSTR_BITS constants, shared with the PC block and the decoder.
- One natural sub-module: fetch_watchdog (timeout counter: clear, count-enable, expired out), instantiated only under FETCH_TIMEOUT_EN.
- FSM and byte assembly stay in instr_fetch.

Test Plan:
- Basic fetch with no wait states:
  - Stimulus: reset released, pc_in=6'h04, fetch_start pulse; memory returns 8'h34 @4 and 8'h12 @5 with immediate ack.
  - Response: mem_addr 4 then 5; instr_out=16'h1234 with instr_valid at start+3; ready → valid=0, busy=0.
- Wait states:
  - Stimulus: mem_ack delayed 3 cycles per byte.
  - Response: mem_req/mem_addr held steady, correct word, valid at start+9.
- Misaligned PC:
  - Stimulus: pc_in=6'h05, fetch_start.
  - Response: one-cycle fetch_err, mem_req never asserted, state remains IDLE.
- Backpressure and ignored start:
  - Stimulus: instr_ready held 0 for 5 cycles with fetch_start pulsing meanwhile.
  - Response: instr_out stable, no new memory request; after ready, next fetch at new pc_in completes normally.
- Reset mid-fetch:
  - Stimulus: reset=0 asserted while in REQ_HI.
  - Response: all outputs zero immediately (asynchronous); a fresh fetch afterwards returns the correct word with no stale low byte.
- Timeout (FETCH_TIMEOUT_EN):
  - Stimulus: never ack.
  - Response: fetch_err pulses after 15 stalled cycles, mem_req drops, IDLE.
  - Also: ack on the 15th cycle completes normally.
